// File: rtl/perceptron_introduction_pkg.sv
// perceptron_introduction_pkg: signed Q32.32 fixed-point type and arithmetic helpers.
// PERCEPTRON_SATURATE_EN switches op_add/op_mul from wrapping to saturating.
package perceptron_introduction_pkg;
  typedef logic signed [63:0] sfp;
  localparam int FRAC_BITS = 32;
  localparam sfp ONE = 64'sh0000_0001_0000_0000;
  localparam sfp SFP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam sfp SFP_MIN = 64'sh8000_0000_0000_0000;

  function automatic sfp int_to_sfp(input int v);
    return sfp'(v) <<< FRAC_BITS;
  endfunction

  function automatic logic signed [127:0] sfp_mul_full(input sfp a, input sfp b);
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    pa = $signed({{64{a[63]}}, a});
    pb = $signed({{64{b[63]}}, b});
    return pa * pb;
  endfunction

  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [127:0] p;
    p = sfp_mul_full(a, b);
    return p[FRAC_BITS +: 64];
  endfunction

  // The shifted product fits in sfp only when bits 127..63 are a pure sign extension.
  function automatic sfp sfp_mul_sat(input sfp a, input sfp b);
    logic signed [127:0] q;
    q = sfp_mul_full(a, b) >>> FRAC_BITS;
    return (q[127:63] == {65{q[127]}}) ? q[63:0] : (q[127] ? SFP_MIN : SFP_MAX);
  endfunction

  function automatic sfp sfp_add_sat(input sfp a, input sfp b);
    sfp s;
    s = a + b;
    return (a[63] == b[63] && s[63] != a[63]) ? (a[63] ? SFP_MIN : SFP_MAX) : s;
  endfunction

  function automatic sfp op_mul(input sfp a, input sfp b);
`ifdef PERCEPTRON_SATURATE_EN
    return sfp_mul_sat(a, b);
`else
    return sfp_mul(a, b);
`endif
  endfunction

  function automatic sfp op_add(input sfp a, input sfp b);
`ifdef PERCEPTRON_SATURATE_EN
    return sfp_add_sat(a, b);
`else
    return a + b;
`endif
  endfunction
endpackage

// File: rtl/perceptron_dot_product.sv
// perceptron_dot_product: s = bias + sum(w[i] * values[i]) in sfp arithmetic.
module perceptron_dot_product
  import perceptron_introduction_pkg::*;
#(
  parameter int input_units = 2
) (
  input  logic [input_units-1:0][63:0] values,
  input  logic [input_units-1:0][63:0] w,
  input  logic signed [63:0]           bias,
  output logic signed [63:0]           sum
);
  always_comb begin
    sum = bias;
    for (int i = 0; i < input_units; i++) sum = op_add(sum, op_mul(sfp'(w[i]), sfp'(values[i])));
  end
endmodule

// File: rtl/perceptron_introduction.sv
// perceptron_introduction: single-layer perceptron, step activation, on-line learning rule.
// Define PERCEPTRON_SATURATE_EN for saturating instead of wrapping arithmetic.
module perceptron_introduction
  import perceptron_introduction_pkg::*;
#(
  parameter int input_units = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [input_units-1:0][63:0] values,
  input  logic                         training,
  input  logic signed [63:0]           learning_rate,
  input  logic signed [63:0]           expected,
  output logic signed [63:0]           prediction
);
  logic [input_units-1:0][63:0] w;
  sfp bias, sum, p, err, delta;

  perceptron_dot_product #(.input_units(input_units)) u_dot (
    .values(values),
    .w(w),
    .bias(bias),
    .sum(sum)
  );

  always_comb begin
    p = (sum > 0) ? ONE : '0;
    err = expected - p;
    delta = op_mul(learning_rate, err);
  end

  // Updates use pre-edge weights and the same p that gets registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prediction <= '0;
      w <= '0;
      bias <= '0;
    end else begin
      prediction <= p;
      if (training) begin
        bias <= op_add(bias, delta);
        for (int i = 0; i < input_units; i++) w[i] <= op_add(sfp'(w[i]), op_mul(delta, sfp'(values[i])));
      end
    end
  end
endmodule

// File: tb/tb_perceptron_introduction.sv
// tb_perceptron_introduction: randomized and directed checks against a behavioural perceptron model.
module tb_perceptron_introduction;
  localparam longint ONE = 64'sh0000_0001_0000_0000;
  localparam longint MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  logic clk = 0;
  logic rst = 0;
  logic training = 0;
  logic [1:0][63:0] values = '0;
  logic signed [63:0] learning_rate = '0;
  logic signed [63:0] expected = '0;
  logic signed [63:0] prediction;
  int total = 0;
  int bad = 0;
  longint wm[2];
  longint bm;

  perceptron_introduction #(.input_units(2)) dut (
    .clk(clk),
    .rst(rst),
    .values(values),
    .training(training),
    .learning_rate(learning_rate),
    .expected(expected),
    .prediction(prediction)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(input logic signed [127:0] v);
`ifdef PERCEPTRON_SATURATE_EN
    if (v > 128'sh7FFF_FFFF_FFFF_FFFF) return 64'sh7FFF_FFFF_FFFF_FFFF;
    if (v < -128'sh8000_0000_0000_0000) return 64'sh8000_0000_0000_0000;
`endif
    return v[63:0];
  endfunction

  function automatic longint mmul(input longint a, input longint b);
    logic signed [127:0] pr;
    pr = a;
    pr = pr * b;
    return clamp(pr >>> 32);
  endfunction

  function automatic longint madd(input longint a, input longint b);
    logic signed [127:0] s;
    s = a;
    s = s + b;
    return clamp(s);
  endfunction

  task automatic model_clear();
    wm[0] = 0;
    wm[1] = 0;
    bm = 0;
  endtask

  task automatic step(input longint x0, input longint x1, input longint ev, input longint lr,
                      input bit tr, input string name, output longint p_obs);
    longint x[2];
    longint s, pe, d;
    x[0] = x0;
    x[1] = x1;
    values[0] = x0;
    values[1] = x1;
    expected = ev;
    learning_rate = lr;
    training = tr;
    s = bm;
    for (int i = 0; i < 2; i++) s = madd(s, mmul(wm[i], x[i]));
    pe = (s > 0) ? ONE : 0;
    if (tr) begin
      d = mmul(lr, ev - pe);
      for (int i = 0; i < 2; i++) wm[i] = madd(wm[i], mmul(d, x[i]));
      bm = madd(bm, d);
    end
    @(posedge clk);
    #1;
    total++;
    if (prediction !== pe) begin
      bad++;
      $display("FAIL %s prediction got=%h want=%h", name, prediction, pe);
    end
    total++;
    if ({dut.w[1], dut.w[0], dut.bias} !== {wm[1], wm[0], bm}) begin
      bad++;
      $display("FAIL %s state got=%h/%h/%h want=%h/%h/%h", name, dut.w[0], dut.w[1], dut.bias, wm[0], wm[1], bm);
    end
    p_obs = prediction;
  endtask

  task automatic pulse_reset();
    rst = 0;
    #2;
    rst = 1;
    model_clear();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      values = {$urandom, $urandom, $urandom, $urandom};
      learning_rate = ONE;
      expected = ONE;
      training = 1;
      @(posedge clk);
      #1;
      total++;
      if (prediction !== 0 || {dut.w[1], dut.w[0], dut.bias} !== 192'd0) begin
        bad++;
        $display("FAIL reset pred=%h w0=%h w1=%h bias=%h want all 0", prediction, dut.w[0], dut.w[1], dut.bias);
      end
    end
    rst = 1;
    model_clear();
  endtask

  task automatic and_epoch(input bit tr, output int acc);
    longint p;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      step((k >> 1) != 0 ? ONE : 0, (k & 1) != 0 ? ONE : 0, k == 3 ? ONE : 0, ONE, tr, "and", p);
      if (p == (k == 3 ? ONE : 0)) acc++;
    end
  endtask

  task automatic test_and();
    int acc;
    and_epoch(1, acc);
    total++;
    if (acc != 3 || {dut.w[1], dut.w[0], dut.bias} !== {ONE, ONE, ONE}) begin
      bad++;
      $display("FAIL and_epoch1 acc=%0d w0=%h w1=%h bias=%h want acc=3 w=(ONE,ONE) bias=ONE", acc, dut.w[0], dut.w[1], dut.bias);
    end
    for (int e = 2; e <= 5; e++) and_epoch(1, acc);
    total++;
    if ({dut.w[1], dut.w[0], dut.bias} !== {ONE, 2 * ONE, -2 * ONE}) begin
      bad++;
      $display("FAIL and_epoch5 w0=%h w1=%h bias=%h want 2ONE/ONE/-2ONE", dut.w[0], dut.w[1], dut.bias);
    end
    and_epoch(0, acc);
    total++;
    if (acc != 4) begin
      bad++;
      $display("FAIL and_infer accuracy got=%0d want=4", acc);
    end
    for (int e = 6; e <= 10; e++) and_epoch(1, acc);
    total++;
    if (acc != 4 || {dut.w[1], dut.w[0], dut.bias} !== {ONE, 2 * ONE, -2 * ONE}) begin
      bad++;
      $display("FAIL and_converged acc=%0d w0=%h w1=%h bias=%h want 4 and unchanged", acc, dut.w[0], dut.w[1], dut.bias);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 0;
    #1;
    total++;
    if (prediction !== 0 || {dut.w[1], dut.w[0], dut.bias} !== 192'd0) begin
      bad++;
      $display("FAIL async_reset pred=%h w0=%h bias=%h want 0 before any edge", prediction, dut.w[0], dut.bias);
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_clear();
  endtask

  task automatic test_hold();
    longint p;
    for (int c = 0; c < 20; c++)
      step({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1) != 0 ? ONE : 0, ONE, 0, "hold", p);
  endtask

  task automatic test_boundary();
    longint p;
    step(-ONE, 0, -ONE, ONE, 1, "bnd_setup", p);
    step(ONE, 0, 0, 0, 0, "bnd_zero", p);
    total++;
    if (p !== 0) begin
      bad++;
      $display("FAIL step_zero prediction got=%h want=0", p);
    end
    step(0, 0, ONE, 1, 1, "bnd_lsb", p);
    step(ONE, 0, 0, 0, 0, "bnd_pos", p);
    total++;
    if (p !== ONE) begin
      bad++;
      $display("FAIL step_lsb prediction got=%h want=%h", p, ONE);
    end
  endtask

  task automatic test_random();
    longint p;
    pulse_reset();
    for (int c = 0; c < 40; c++)
      step((longint'($urandom_range(0, 16)) - 8) * (ONE / 2), (longint'($urandom_range(0, 16)) - 8) * (ONE / 2),
           $urandom_range(0, 1) != 0 ? ONE : 0, ONE >> $urandom_range(0, 3), $urandom_range(0, 3) != 0, "random", p);
  endtask

  task automatic test_saturation();
    longint p;
    pulse_reset();
    step(ONE, 0, 2 * ONE, 64'sh3000_0000_0000_0000, 1, "sat1", p);
    step(ONE, 0, 2 * ONE, 64'sh3000_0000_0000_0000, 1, "sat2", p);
    total++;
`ifdef PERCEPTRON_SATURATE_EN
    if (dut.w[0] !== MAXV) begin
      bad++;
      $display("FAIL sat_clamp w0 got=%h want=%h", dut.w[0], MAXV);
    end
`else
    if (dut.w[0][63] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_negative w0 got=%h want negative", dut.w[0]);
    end
`endif
  endtask

  initial begin
    model_clear();
    test_reset();
    test_and();
    test_async_reset();
    test_hold();
    test_boundary();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/perceptron_introduction.md
Name: perceptron_introduction

Overview:
- Single-layer perceptron with a step activation and an on-line perceptron learning rule, built on the team's signed fixed-point type `sfp`.
- Each clock it evaluates the weighted sum of `input_units` inputs plus a bias, and registers a binary prediction (0 or ONE).
- When `training` is high, it updates its weights and bias in the same cycle.
- It is a teaching/demo block that sits standalone under a bench driving logic-gate truth tables.

Parameters:
- input_units, 2, number of inputs, i.e. the number of weights (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- values  in  sfp[input_units]  input vector x[i].
- training  in  1  1 = apply the learning update this cycle; 0 = inference only.
- learning_rate  in  sfp  step size lr.
- expected  in  sfp  target label, 0 or ONE.
- prediction  out  sfp  registered step output, 0 or ONE.

Behaviour:
- sfp format: signed 64-bit Q32.32; ONE = 1<<32 = 0x0000_0001_0000_0000.
- Fixed-point multiply: full 128-bit signed product, arithmetic shift right by 32, keep the low 64 bits (wrap).
- State: w[0..input_units-1] and bias, all sfp.
- Reset (rst=0, asynchronous): all w = 0, bias = 0, prediction = 0.
- Reset mid-training discards all learned state.
- Combinational sum: s = bias + Σ mul(w[i], values[i]), accumulated in sfp width (wrap).
- Step function: p = ONE if s > 0, else 0. s == 0 gives 0.
- Every rising edge: prediction <= p. Latency is one edge: inputs applied before edge k appear on `prediction` just after edge k.
- When training=1 on that edge:
  - err = expected − p (sfp subtract).
  - delta = mul(learning_rate, err).
  - w[i] <= w[i] + mul(delta, values[i]); bias <= bias + delta.
  - The update uses the pre-edge weights and the same p that is registered. All weights and the bias update simultaneously.
- When training=0: weights and bias hold.
- err == 0 leaves the state unchanged even with training=1.
- No handshake; every cycle is a valid sample.
- `expected` values other than 0/ONE are accepted; the arithmetic applies as defined.

Optional Feature:
- Macro PERCEPTRON_SATURATE_EN.
- Defined:
  - The multiply result, the sum accumulation, and each weight/bias update saturate to the sfp range: max 0x7FFF…F, min 0x8000…0.
  - Step comparison uses the saturated sum.
- Undefined: all arithmetic wraps modulo 2^64 as described above.
- Results are identical for in-range values.

Decomposition:
- Package FixedPoint (shared, already used by the codebase):
  - typedef sfp (logic signed [63:0]), FRAC_BITS = 32, ONE.
  - Functions int_to_sfp, sfp_mul (wrapping), and sfp_add_sat / sfp_mul_sat for the optional feature.
- One natural sub-module: perceptron_dot_product. It computes s from values, w and bias, and is shared by evaluation and training.

Test Plan:
- Reset: hold rst=0 for 3 cycles with arbitrary inputs → prediction=0, all w=0, bias=0. Assert rst=0 mid-run → prediction returns to 0 immediately, without waiting for a clock.
- AND epoch 1: lr=ONE, training=1, apply [0,0]/0, [0,1]/0, [1,0]/0, [1,1]/ONE, one per edge.
  - Predictions 0,0,0,0.
  - After the 4th edge: w=(ONE,ONE), bias=ONE.
- AND convergence: continue the same epochs.
  - After epoch 5: w=(2·ONE, ONE), bias=−2·ONE.
  - Inference (training=0) on the four patterns gives 0,0,0,ONE; accuracy 4/4.
  - 10 epochs total remain 4/4 with weights unchanged after convergence.
- Inference hold: training=0, w=0 → for 20 cycles of random inputs, prediction=0 and weights unchanged.
- Step boundary: set the state so s is exactly 0 (bias=−ONE, w0=ONE, x=[ONE,0]) → prediction=0. Bias=−ONE+1 LSB → prediction=ONE.
- Saturation: with PERCEPTRON_SATURATE_EN defined, drive w near max and train toward larger values → w clamps at 0x7FFF_FFFF_FFFF_FFFF. Undefined → w wraps negative.
